// File: rtl/bht_pkg.sv
// Shared branch-prediction constants: 2-bit counter states and the branch-type encoding
// used by the BHT, the BTB and the EX stage.
package bht_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_COND = 3'd1,
      BR_JAL  = 3'd2,
      BR_JALR = 3'd3,
      BR_CALL = 3'd4,
      BR_RET  = 3'd5
   } br_type_e;

   function automatic logic ctr_taken(input logic [1:0] ctr);
      return ctr[1];
   endfunction

   function automatic logic is_branch(input logic [2:0] br_type);
      return br_type != BR_NONE;
   endfunction

endpackage

// File: rtl/bht_sat_ctr2.sv
// Next-state function of one 2-bit saturating counter; purely combinational, zero latency,
// no backpressure.
module sat_ctr2
   import bht_pkg::*;
(
   input  logic [1:0] i_cur,
   input  logic       i_taken,
   output logic [1:0] o_next
);

   always_comb begin
      o_next = i_cur;
      if (i_taken) begin
         if (i_cur != ST) o_next = i_cur + 2'd1;
      end else begin
         if (i_cur != SNT) o_next = i_cur - 2'd1;
      end
   end

endmodule

// File: rtl/bht.sv
// Branch history table: zero-latency lookup from fetch PC, one-cycle update from EX, no backpressure.
// Define BHT_GSHARE_EN to XOR the PC index with a global history register (gshare mode).
module bht
   import bht_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_idx,
   input  logic [31:0]      PCE,
   input  logic [2:0]       BranchTypeE,
   input  logic             BranchE,
   input  logic             peE,
   input  logic [IDX_W-1:0] idxE,
   output logic             mispredict,
   output logic [31:0]      br_cnt,
   output logic [31:0]      miss_cnt
);

   logic [1:0]       r_table [ENTRIES];
   logic [31:0]      r_br_cnt;
   logic [31:0]      r_miss_cnt;

   logic [IDX_W-1:0] w_pc_idx;
   logic [IDX_W-1:0] w_lookup_idx;
   logic             w_upd;
   logic             w_miss;
   logic [1:0]       w_cur;
   logic [1:0]       w_next;
   logic             w_unused;

   assign w_pc_idx = addr[IDX_W+1:2];
   assign w_upd    = is_branch(BranchTypeE);
   assign w_miss   = w_upd & (peE != BranchE);

   // EX already carries the index it was predicted with, so PCE is never re-hashed.
   assign w_unused = ^{PCE, addr[31:IDX_W+2], addr[1:0]};

`ifdef BHT_GSHARE_EN
   logic [IDX_W-1:0] r_ghr;

   assign w_lookup_idx = w_pc_idx ^ r_ghr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ghr <= '0;
      end else if (w_upd) begin
         r_ghr <= {r_ghr[IDX_W-2:0], BranchE};
      end
   end
`else
   assign w_lookup_idx = w_pc_idx;
`endif

   // Table reads see the pre-edge contents, giving read-before-write on an index collision.
   assign pred_idx   = w_lookup_idx;
   assign pred_taken = ctr_taken(r_table[w_lookup_idx]);
   assign mispredict = w_miss;
   assign br_cnt     = r_br_cnt;
   assign miss_cnt   = r_miss_cnt;

   assign w_cur = r_table[idxE];

   sat_ctr2 u_sat_ctr2 (
      .i_cur   (w_cur),
      .i_taken (BranchE),
      .o_next  (w_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_table[i] <= WNT;
         end
      end else if (w_upd) begin
         r_table[idxE] <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_br_cnt   <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_upd)  r_br_cnt   <= r_br_cnt + 32'd1;
         if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

endmodule

// File: doc/bht.md
BHT -- requirements
Module: bht

Interface
REQ-001 Parameter ENTRIES, default 64; number of 2-bit counters, power of two, 8..1024.
REQ-002 Parameter IDX_W, default 6; log2(ENTRIES), and also the global-history width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 addr  in  32  fetch PC being looked up, same value the BTB receives.
REQ-006 pred_taken  out  1  predicted direction for addr; carried down the pipeline as pe.
REQ-007 pred_idx  out  IDX_W  table index used for addr; carried down the pipeline with pe.
REQ-008 PCE  in  32  PC of the branch in EX.
REQ-009 BranchTypeE  in  3  nonzero means the instruction in EX is a branch.
REQ-010 BranchE  in  1  resolved taken flag from EX.
REQ-011 peE  in  1  pred_taken value carried to EX with that branch.
REQ-012 idxE  in  IDX_W  pred_idx value carried to EX with that branch.
REQ-013 mispredict  out  1  EX direction misprediction.
REQ-014 br_cnt  out  32  number of resolved branches.
REQ-015 miss_cnt  out  32  number of mispredicted branches.

Function
REQ-016 The table SHALL hold ENTRIES 2-bit saturating counters with encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 Lookup index SHALL be addr[IDX_W+1:2], modified per REQ-033.
REQ-018 pred_taken SHALL be bit 1 of the indexed counter, combinational from addr, zero-cycle latency.
REQ-019 pred_idx SHALL equal the lookup index, combinational.
REQ-020 An update SHALL occur only when BranchTypeE != 0; it writes entry idxE and ignores PCE bits.
REQ-021 On update, BranchE=1 SHALL increment the entry, saturating at 11; BranchE=0 SHALL decrement it, saturating at 00.
REQ-022 When a lookup and an update hit the same index in one cycle, pred_taken SHALL show the pre-update value (read-before-write).
REQ-023 mispredict SHALL equal (BranchTypeE != 0) & (peE != BranchE), combinational.
REQ-024 br_cnt SHALL increment on every update cycle, and miss_cnt SHALL increment when mispredict=1; both wrap from 0xFFFFFFFF to 0.
REQ-025 When BranchTypeE = 0, no table, history or counter state SHALL change.

Reset
REQ-026 While rst=1 at a rising edge, every counter SHALL be set to 01 (weak-NT), and br_cnt, miss_cnt and the history register SHALL be set to 0.
REQ-027 rst SHALL take priority over a simultaneous update; the update is dropped.
REQ-028 After reset, pred_taken SHALL be 0 for every addr until the first taken update.
REQ-029 The block SHALL contain no initial blocks; reset is the only initialisation.

Configuration
REQ-030 Macro BHT_GSHARE_EN SHALL select the indexing mode.
REQ-031 When BHT_GSHARE_EN is defined, the block SHALL hold an IDX_W-bit global history register ghr.
REQ-032 On each update, ghr SHALL become {ghr[IDX_W-2:0], BranchE}.
REQ-033 When BHT_GSHARE_EN is defined, the lookup index SHALL be addr[IDX_W+1:2] ^ ghr, using the pre-edge ghr.
REQ-034 When BHT_GSHARE_EN is undefined, ghr SHALL not exist, and indexing SHALL be plain PC bits.
REQ-035 In both modes, updates SHALL use idxE, so no re-hash is needed in EX.

Structure
REQ-036 A shared package SHALL hold the counter-state constants (SNT, WNT, WT, ST) and the branch-type encoding shared with the BTB and EX stage.
REQ-037 A sub-module sat_ctr2 SHALL implement the next-state function of one 2-bit saturating counter; bht instantiates it once, on the update path.
REQ-038 The table SHALL be a register array, with no memory macro, so that reset covers every entry.

Verification
REQ-039 Scenario: assert rst, then lookup addr=0x00000040 -> pred_taken=0, pred_idx=16, and br_cnt=miss_cnt=0.
REQ-040 Scenario: PCE=0x40 (idxE=16), BranchTypeE=1, BranchE=1, peE=0, for 3 cycles -> entry 16 goes 01->10->11->11, mispredict=1 each cycle, miss_cnt=3, br_cnt=3.
REQ-041 Scenario: from entry=11, four not-taken updates -> 10, 01, 00, 00; pred_taken for addr=0x40 flips to 0 after the second update.
REQ-042 Scenario: same-cycle lookup addr=0x40 and taken update idxE=16 from 01 -> pred_taken=0 that cycle and 1 the next cycle.
REQ-043 Scenario: assert rst in the same cycle as an update with BranchE=1 -> entry stays 01 and br_cnt=0.
REQ-044 Scenario (BHT_GSHARE_EN defined): from reset, two taken updates make ghr=000011, and then lookup addr=0x40 -> pred_idx=16^3=19.
